// File: rtl/pll_reset_pkg.sv
// Shared types and helpers for the PLL reset controller.
// FAULT exists in every build; it is unreachable when PLL_AUTO_RELOCK_EN is defined.
package pll_reset_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_e;

    // Width of the shared counter. It is at least one bit, even when every limit is 1.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-high reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: resets the PLL, waits for lock with timeout/retry, qualifies it, then releases sys_reset.
// Build option PLL_AUTO_RELOCK_EN: re-reset the PLL on lock loss instead of entering sticky FAULT.
module pll_reset_ctrl
    import pll_reset_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned RETRY_W       = 4
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               sys_reset,
    output logic               ready,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int unsigned CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             locked_s;
    logic             retry_inc;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock takes priority over a timeout landing in the same cycle.
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = RESET_PLL;
                    retry_inc = 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s)                state_d = WAIT_LOCK;
                else if (cnt_q == STB_LAST) state_d = RUN;
            end
            RUN: begin
                if (!locked_s) begin
                    retry_inc = 1'b1;
`ifdef PLL_AUTO_RELOCK_EN
                    state_d = RESET_PLL;
`else
                    state_d = FAULT;
`endif
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = RESET_PLL;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            pll_rst     <= 1'b1;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
            lock_lost   <= 1'b0;
            retry_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q != RUN && state_q != FAULT) begin
                cnt_q <= cnt_q + 1'b1;
            end
            pll_rst   <= (state_d == RESET_PLL) || (state_d == FAULT);
            sys_reset <= (state_d != RUN);
            ready     <= (state_d == RUN);
            lock_lost <= (state_q == RUN) && !locked_s;
            if (retry_inc && (retry_count != '1)) retry_count <= retry_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, RETRY_W=2.
// Checks both builds; the lock-loss expectations follow PLL_AUTO_RELOCK_EN.
module tb_pll_reset_ctrl;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       lock_lost;
    logic [1:0] retry_count;

    int checks = 0;
    int errors = 0;

    always #10 refclk = ~refclk;

    pll_reset_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .RETRY_W       (2)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .lock_lost   (lock_lost),
        .retry_count (retry_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    // From rst release (or a timeout) pll_rst stays high through 3 more edges, drops on the 4th.
    task automatic reset_phase(input string tag);
        tick(3);
        check({tag, " pll_rst held"}, int'(pll_rst), 1);
        tick(1);
        check({tag, " pll_rst released"}, int'(pll_rst), 0);
    endtask

    task automatic restart();
        rst = 1'b1;
        pll_locked = 1'b0;
        tick(2);
        rst = 1'b0;
        reset_phase("restart");
    endtask

    initial begin
        // Reset values
        tick(2);
        check("reset pll_rst", int'(pll_rst), 1);
        check("reset sys_reset", int'(sys_reset), 1);
        check("reset ready", int'(ready), 0);
        check("reset lock_lost", int'(lock_lost), 0);
        check("reset retry", int'(retry_count), 0);

        // 1: no lock -> repeated timeouts, retry_count saturates at 3
        rst = 1'b0;
        reset_phase("t1");
        for (int a = 1; a <= 4; a++) begin
            tick(19);
            check("t1 wait pll_rst low", int'(pll_rst), 0);
            tick(1);
            check("t1 timeout pll_rst", int'(pll_rst), 1);
            check("t1 retry", int'(retry_count), (a > 3) ? 3 : a);
            reset_phase("t1");
        end

        // 2: lock 5 cycles into WAIT_LOCK, ready exactly 11 edges later
        restart();
        check("t2 retry cleared", int'(retry_count), 0);
        tick(5);
        pll_locked = 1'b1;
        tick(10);
        check("t2 ready early", int'(ready), 0);
        check("t2 sys_reset early", int'(sys_reset), 1);
        tick(1);
        check("t2 ready", int'(ready), 1);
        check("t2 sys_reset", int'(sys_reset), 0);
        check("t2 lock_lost", int'(lock_lost), 0);

        // 4: lock loss in RUN
        pll_locked = 1'b0;
        tick(2);
        check("t4 ready before seen", int'(ready), 1);
        tick(1);
        check("t4 lock_lost pulse", int'(lock_lost), 1);
        check("t4 sys_reset", int'(sys_reset), 1);
        check("t4 ready", int'(ready), 0);
        check("t4 retry", int'(retry_count), 1);
        tick(1);
        check("t4 lock_lost cleared", int'(lock_lost), 0);
`ifdef PLL_AUTO_RELOCK_EN
        tick(2);
        check("t4 relock pll_rst held", int'(pll_rst), 1);
        tick(1);
        check("t4 relock pll_rst released", int'(pll_rst), 0);
        pll_locked = 1'b1;
        tick(10);
        check("t4 relock ready early", int'(ready), 0);
        tick(1);
        check("t4 relock ready", int'(ready), 1);
        check("t4 relock retry", int'(retry_count), 1);
`else
        tick(2);
        check("t4 fault pll_rst", int'(pll_rst), 1);
        pll_locked = 1'b1;
        tick(30);
        check("t4 fault sticky pll_rst", int'(pll_rst), 1);
        check("t4 fault ready", int'(ready), 0);
        check("t4 fault sys_reset", int'(sys_reset), 1);
        check("t4 fault retry", int'(retry_count), 1);
`endif

        // 3: lock drop during STABLE restarts the full qualification
        restart();
        tick(1);
        pll_locked = 1'b1;
        tick(5);
        pll_locked = 1'b0;
        tick(3);
        check("t3 ready during drop", int'(ready), 0);
        pll_locked = 1'b1;
        tick(10);
        check("t3 ready early", int'(ready), 0);
        tick(1);
        check("t3 ready", int'(ready), 1);
        check("t3 retry unchanged", int'(retry_count), 0);

        // 5a: asynchronous rst mid-STABLE
        restart();
        pll_locked = 1'b1;
        tick(6);
        check("t5 stable pll_rst", int'(pll_rst), 0);
        rst = 1'b1;
        #2;
        check("t5 stable async pll_rst", int'(pll_rst), 1);
        check("t5 stable async sys_reset", int'(sys_reset), 1);
        check("t5 stable async ready", int'(ready), 0);

        // 5b: asynchronous rst mid-RUN with a nonzero retry_count
        pll_locked = 1'b0;
        tick(1);
        rst = 1'b0;
        reset_phase("t5");
        tick(20);
        check("t5 retry before", int'(retry_count), 1);
        reset_phase("t5");
        pll_locked = 1'b1;
        tick(13);
        check("t5 run ready", int'(ready), 1);
        rst = 1'b1;
        #2;
        check("t5 run async ready", int'(ready), 0);
        check("t5 run async sys_reset", int'(sys_reset), 1);
        check("t5 run async pll_rst", int'(pll_rst), 1);
        check("t5 run async retry", int'(retry_count), 0);
        check("t5 run async lock_lost", int'(lock_lost), 0);

        // 6: locked_s rises exactly when the timeout counter hits 19
        pll_locked = 1'b0;
        tick(1);
        rst = 1'b0;
        reset_phase("t6");
        tick(17);
        pll_locked = 1'b1;
        tick(3);
        check("t6 no retry pll_rst", int'(pll_rst), 0);
        check("t6 no retry", int'(retry_count), 0);
        tick(7);
        check("t6 ready early", int'(ready), 0);
        tick(1);
        check("t6 ready", int'(ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_ctrl.md
Name: pll_reset_ctrl

Overview:
- Companion controller on the PLL's rst/locked interface: drives the PLL reset input and consumes its locked output.
- Runs on the free-running board reference clock (50 MHz), upstream of the PLL.
- Sequences PLL reset, waits for lock with timeout/retry, qualifies lock stability, then releases a system reset for core logic.
- On lock loss, detects it and recovers.

Parameters:
- RST_CYCLES, 16, refclk cycles pll_rst is held high per reset attempt (>=1).
- LOCK_TIMEOUT, 65536, refclk cycles to wait for lock before retrying (>=1).
- STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release (>=1).
- RETRY_W, 4, width of the saturating retry/loss counter.

Ports:
- refclk  input  1  free-running reference clock; sole clock.
- rst  input  1  asynchronous, active-high reset.
- pll_locked  input  1  PLL locked; asynchronous to refclk.
- pll_rst  output  1  reset to PLL, active-high.
- sys_reset  output  1  active-high reset for core logic; low only in RUN.
- ready  output  1  high only in RUN.
- lock_lost  output  1  one-cycle pulse on lock loss in RUN.
- retry_count  output  RETRY_W  saturating count of timeouts plus lock losses.

Behaviour:
- Interface: one clock (refclk); reset rst is asynchronous and active-high.
- pll_locked passes through a 2-FF synchronizer → locked_s, giving 2 cycles of latency.
- All outputs are registered and decoded from the state register.
- Reset values: state=RESET_PLL, pll_rst=1, sys_reset=1, ready=0, lock_lost=0, retry_count=0, counter=0, synchronizer=0.
- One shared counter, width $clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)), cleared on every state change.
- RESET_PLL:
  - pll_rst=1.
  - When counter==RST_CYCLES-1 → WAIT_LOCK, so pll_rst is high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst=0.
  - If locked_s → STABLE.
  - Else if counter==LOCK_TIMEOUT-1 → RESET_PLL and retry_count++.
  - If locked_s and the timeout occur in the same cycle, locked_s wins.
- STABLE:
  - If !locked_s → WAIT_LOCK with the counter cleared; no retry increment.
  - Else if counter==STABLE_CYCLES-1 → RUN.
- RUN:
  - sys_reset=0, ready=1.
  - If !locked_s → lock_lost=1 for the next cycle, retry_count++, and exit per the Optional Feature.
- retry_count saturates at 2^RETRY_W-1 and never wraps.
- sys_reset is high in every state except RUN, including the cycle after the lock drop is seen.
- rst asserted mid-operation: immediately forces all reset values and restarts from RESET_PLL; retry_count is cleared.
- Glitches on pll_locked shorter than one refclk cycle may or may not be seen; either outcome must leave the FSM in a legal state.

Optional Feature:
- Macro: PLL_AUTO_RELOCK_EN.
- Defined: on lock loss in RUN → RESET_PLL, an automatic re-reset of the PLL.
- Undefined: on lock loss in RUN → FAULT.
  - FAULT is sticky: pll_rst=1, sys_reset=1, ready=0.
  - FAULT is left only via rst.
- Both builds raise the lock_lost pulse and increment retry_count identically.

Decomposition:
- Package pll_reset_pkg:
  - state enum {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT}, with FAULT present in both builds but unreachable when PLL_AUTO_RELOCK_EN is defined.
  - localparam helper function for the counter width.
- Sub-module sync_2ff: generic 2-flop synchronizer with async reset, used for pll_locked.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, RETRY_W=2.
1. Release rst, hold pll_locked=0 → pll_rst high exactly 4 cycles, then low 20 cycles, then high again; retry_count 0→1→2→3 and holds at 3 after further timeouts.
2. Raise pll_locked 5 cycles into WAIT_LOCK, then hold it → ready and sys_reset toggle exactly 2+8+1 cycles after the edge; lock_lost stays 0.
3. Drop pll_locked for 3 cycles during STABLE → FSM returns to WAIT_LOCK; retry_count unchanged; full 8-cycle qualification restarts on relock.
4. Drop pll_locked in RUN:
   - both builds: lock_lost=1 for one cycle, sys_reset=1, retry_count+1;
   - with PLL_AUTO_RELOCK_EN: pll_rst pulses 4 cycles and the normal sequence repeats;
   - without it: pll_rst stays 1 forever until rst.
5. Assert rst asynchronously, mid-STABLE and mid-RUN → outputs reach reset values without a refclk edge; retry_count=0.
6. Lock arrives in the same cycle as timeout (locked_s rises at counter==19) → transitions to STABLE; no retry increment.
